// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C responder modelling a byte-addressed serial EEPROM.
// SCL/SDA are oversampled on sys_clk. The block decodes START/STOP, the
// device address and one or two word-address bytes. It supports multi-byte
// writes and reads with auto-increment. The pointer wraps modulo 2^MEM_AW.
// Optional feature macro: I2C_SLV_WP_EN adds the wp (write-protect) input.
module i2c_eeprom_slave #(
  parameter logic [6:0]  DEVICE_ADDR = 7'b1010_000,
  parameter logic        ADDR_NUM    = 1'b1,
  parameter int unsigned MEM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i2c_scl,
  inout  logic              i2c_sda,
  output logic              busy,
  output logic              mem_wr,
  output logic [MEM_AW-1:0] mem_wr_addr
`ifdef I2C_SLV_WP_EN
  ,
  input  logic              wp
`endif
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t            state_q;
  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_hist_q, sda_hist_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        rx_q;
  logic [6:0]        tx_q;
  logic [7:0]        addr_h_q;
  logic [MEM_AW-1:0] ptr_q;
  logic              rw_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic              mem_wr_q;
  logic [MEM_AW-1:0] mem_wr_addr_q;
  logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

  logic              scl_s, sda_s;
  logic              start_ev, stop_ev, scl_rise, scl_fall;
  logic              byte_done, wr_commit, wp_act;
  logic [7:0]        rd_byte;
  logic [MEM_AW-1:0] ptr_load;

`ifdef I2C_SLV_WP_EN
  assign wp_act = wp;
`else
  assign wp_act = 1'b0;
`endif

  // Two-flop synchronizers plus one history flop; reset to bus-idle high
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign start_ev  = scl_s & sda_hist_q & ~sda_s;
  assign stop_ev   = scl_s & ~sda_hist_q & sda_s;
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign byte_done = scl_fall & (bit_cnt_q == 4'd8);
  assign wr_commit = (state_q == WR_DATA) & byte_done & ~start_ev & ~stop_ev & ~wp_act;
  assign rd_byte   = mem_q[ptr_q];
  assign ptr_load  = ADDR_NUM ? MEM_AW'({addr_h_q, rx_q}) : MEM_AW'(rx_q);

  // Storage array, deliberately not reset so contents survive sys_rst
  always_ff @(posedge sys_clk) begin
    if (wr_commit) mem_q[ptr_q] <= rx_q;
  end

  // Protocol FSM: START/STOP first, then SCL rise (sample) and fall (drive)
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      addr_h_q      <= '0;
      ptr_q         <= '0;
      rw_q          <= 1'b0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wr_addr_q <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      if (start_ev) begin
        state_q   <= DEV_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_ev) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (scl_rise) begin
        rx_q      <= {rx_q[6:0], sda_s};
        bit_cnt_q <= bit_cnt_q + 4'd1;
        if (state_q == RD_ACK) begin
          ptr_q <= ptr_q + MEM_AW'(1);
          if (sda_s) state_q <= IGNORE;
        end
      end else if (scl_fall) begin
        case (state_q)
          DEV_ADDR: if (byte_done) begin
            bit_cnt_q <= '0;
            rw_q      <= rx_q[0];
            if (rx_q[7:1] == DEVICE_ADDR) begin
              state_q  <= DEV_ACK;
              busy_q   <= 1'b1;
              sda_oe_q <= 1'b1;
            end else begin
              state_q  <= IGNORE;
            end
          end
          DEV_ACK: begin
            bit_cnt_q <= '0;
            if (rw_q) begin
              state_q  <= RD_DATA;
              tx_q     <= rd_byte[6:0];
              sda_oe_q <= ~rd_byte[7];
            end else begin
              state_q  <= ADDR_NUM ? ADDR_H : ADDR_L;
              sda_oe_q <= 1'b0;
            end
          end
          ADDR_H: if (byte_done) begin
            bit_cnt_q <= '0;
            addr_h_q  <= rx_q;
            state_q   <= ADDR_H_ACK;
            sda_oe_q  <= 1'b1;
          end
          ADDR_H_ACK: begin
            bit_cnt_q <= '0;
            state_q   <= ADDR_L;
            sda_oe_q  <= 1'b0;
          end
          ADDR_L: if (byte_done) begin
            bit_cnt_q <= '0;
            ptr_q     <= ptr_load;
            state_q   <= ADDR_L_ACK;
            sda_oe_q  <= 1'b1;
          end
          ADDR_L_ACK: begin
            bit_cnt_q <= '0;
            state_q   <= WR_DATA;
            sda_oe_q  <= 1'b0;
          end
          WR_DATA: if (byte_done) begin
            bit_cnt_q <= '0;
            state_q   <= WR_ACK;
            if (wp_act) begin
              sda_oe_q <= 1'b0;
            end else begin
              sda_oe_q      <= 1'b1;
              mem_wr_q      <= 1'b1;
              mem_wr_addr_q <= ptr_q;
              ptr_q         <= ptr_q + MEM_AW'(1);
            end
          end
          WR_ACK: begin
            bit_cnt_q <= '0;
            state_q   <= WR_DATA;
            sda_oe_q  <= 1'b0;
          end
          // MSB already on the bus from entry; each later fall shifts the next bit out
          RD_DATA: begin
            if (byte_done) begin
              bit_cnt_q <= '0;
              state_q   <= RD_ACK;
              sda_oe_q  <= 1'b0;
            end else if (bit_cnt_q != 4'd0) begin
              tx_q     <= {tx_q[5:0], 1'b0};
              sda_oe_q <= ~tx_q[6];
            end
          end
          // Only reached after an ACK was sampled; ptr already advanced on that rise
          RD_ACK: if (bit_cnt_q != 4'd0) begin
            bit_cnt_q <= '0;
            state_q   <= RD_DATA;
            tx_q      <= rd_byte[6:0];
            sda_oe_q  <= ~rd_byte[7];
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy        = busy_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wr_addr = mem_wr_addr_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Self-checking bench for i2c_eeprom_slave: bit-banged I2C controller,
// table-driven byte write/read vectors, corner-case sequences and a
// randomized phase checked against a flat array model of the EEPROM.
module tb_i2c_eeprom_slave;

  localparam int Q = 5;  // quarter SCL period in sys_clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       scl;
  logic       m_oe;
  wire        sda;
  logic       busy, mem_wr;
  logic [7:0] mem_wr_addr;
`ifdef I2C_SLV_WP_EN
  logic       wp;
`endif

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_eeprom_slave #(.DEVICE_ADDR(7'h50), .ADDR_NUM(1'b1), .MEM_AW(8)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .i2c_scl(scl),
    .i2c_sda(sda),
    .busy(busy),
    .mem_wr(mem_wr),
    .mem_wr_addr(mem_wr_addr)
`ifdef I2C_SLV_WP_EN
    ,
    .wp(wp)
`endif
  );

  // Bus monitors
  int         wr_pulses = 0;
  logic [7:0] last_wr_addr = 8'h00;
  int         dut_low = 0;
  int         busy_cnt = 0;
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_pulses++;
      last_wr_addr = mem_wr_addr;
    end
    if (!m_oe && sda === 1'b0) dut_low++;
    if (busy === 1'b1) busy_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: flat byte array plus pointer
  logic [7:0] mdl [256];
  bit         known [256];
  logic [7:0] mptr = 8'h00;
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  int         nacks;

  function automatic void m_write(input logic [7:0] a);
    logic [7:0] p = a;
    foreach (wq[i]) begin
      mdl[p] = wq[i];
      known[p] = 1'b1;
      p = p + 8'd1;
    end
    mptr = p;
  endfunction

  task automatic check_reads(input string tag, input logic [7:0] a);
    logic [7:0] p = a;
    foreach (rq[i]) begin
      if (known[p]) check(tag, rq[i], mdl[p]);
      p = p + 8'd1;
    end
    mptr = p;
  endtask

  // Bit-level controller
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_bit(input logic b);
    tick(Q); m_oe = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(Q); m_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    b = (sda !== 1'b0); tick(Q); scl = 1'b0;
  endtask

  task automatic do_start();
    if (!scl) begin
      tick(Q); m_oe = 1'b0; tick(Q); scl = 1'b1;
    end
    tick(Q); m_oe = 1'b1; tick(Q); scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(Q); m_oe = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_oe = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(nack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      get_bit(t);
      b[i] = t;
    end
    put_bit(nack);
  endtask

  task automatic send_cnt(input logic [7:0] b);
    logic n;
    send_byte(b, n);
    if (n) nacks++;
  endtask

  task automatic set_addr(input logic [7:0] a);
    do_start(); send_cnt(8'hA0); send_cnt(8'h00); send_cnt(a);
  endtask

  task automatic write_txn(input logic [7:0] a);
    nacks = 0;
    set_addr(a);
    foreach (wq[i]) send_cnt(wq[i]);
    do_stop();
  endtask

  task automatic recv_n(input int n);
    logic [7:0] b;
    rq.delete();
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      rq.push_back(b);
    end
    do_stop();
  endtask

  task automatic read_txn(input logic [7:0] a, input int n);
    nacks = 0;
    set_addr(a); do_start(); send_cnt(8'hA1);
    recv_n(n);
  endtask

  task automatic cur_read(input int n);
    nacks = 0;
    do_start(); send_cnt(8'hA1);
    recv_n(n);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_wr_addr;
    int         exp_pulses;
  } vec_t;
  vec_t vt[6];

  initial begin
    int w0, l0, b0, n;
    logic nk, bt;
    logic [7:0] a;

    vt[0] = '{8'h00, 8'h5A, 8'h5A, 8'h00, 1};
    vt[1] = '{8'hFF, 8'hC3, 8'hC3, 8'hFF, 1};
    vt[2] = '{8'h80, 8'h01, 8'h01, 8'h80, 1};
    vt[3] = '{8'h7F, 8'hFE, 8'hFE, 8'h7F, 1};
    vt[4] = '{8'h3C, 8'h00, 8'h00, 8'h3C, 1};
    vt[5] = '{8'h55, 8'hFF, 8'hFF, 8'h55, 1};

    rst = 1'b1; scl = 1'b1; m_oe = 1'b0;
`ifdef I2C_SLV_WP_EN
    wp = 1'b0;
`endif
    tick(5);
    check("reset_busy", busy, 0);
    check("reset_mem_wr", mem_wr, 0);
    check("reset_wr_addr", mem_wr_addr, 0);
    check("reset_sda_released", sda, 1);
    rst = 1'b0;
    tick(10);

    // Byte write then random read
    wq = {8'hA5};
    w0 = wr_pulses; nacks = 0;
    do_start(); send_cnt(8'hA0);
    check("busy_after_match", busy, 1);
    send_cnt(8'h00); send_cnt(8'h12); send_cnt(8'hA5); do_stop();
    check("bw_acks", nacks, 0);
    check("bw_pulses", wr_pulses - w0, 1);
    check("bw_wr_addr", last_wr_addr, 8'h12);
    check("busy_after_stop", busy, 0);
    m_write(8'h12);
    read_txn(8'h12, 1);
    check("rr_acks", nacks, 0);
    check("rr_data", rq[0], 8'hA5);
    mptr = 8'h13;

    // Table of single-byte write / read-back vectors
    foreach (vt[i]) begin
      wq = {vt[i].data};
      w0 = wr_pulses;
      write_txn(vt[i].addr);
      check("tbl_wr_acks", nacks, 0);
      check("tbl_pulses", wr_pulses - w0, vt[i].exp_pulses);
      check("tbl_wr_addr", last_wr_addr, vt[i].exp_wr_addr);
      m_write(vt[i].addr);
      read_txn(vt[i].addr, 1);
      check("tbl_rd_acks", nacks, 0);
      check("tbl_rd", rq[0], vt[i].exp_rd);
      mptr = vt[i].addr + 8'd1;
    end

    // Sequential write/read across the 0xFF -> 0x00 wrap
    wq = {8'h44}; write_txn(8'h01); m_write(8'h01);
    wq = {8'h11, 8'h22, 8'h33};
    w0 = wr_pulses;
    write_txn(8'hFE);
    check("wrap_wr_acks", nacks, 0);
    check("wrap_pulses", wr_pulses - w0, 3);
    check("wrap_last_addr", last_wr_addr, 8'h00);
    m_write(8'hFE);
    read_txn(8'hFE, 3);
    check("wrap_rd_acks", nacks, 0);
    check("wrap_rd0", rq[0], 8'h11);
    check("wrap_rd1", rq[1], 8'h22);
    check("wrap_rd2", rq[2], 8'h33);
    mptr = 8'h01;
    cur_read(1);
    check("wrap_ptr_end", rq[0], 8'h44);
    mptr = 8'h02;

    // Address mismatch: never drive SDA, never busy
    l0 = dut_low; b0 = busy_cnt;
    do_start(); send_byte(8'hA2, nk);
    check("mismatch_nack", nk, 1);
    send_byte(8'h00, nk);
    check("mismatch_nack2", nk, 1);
    do_stop();
    check("mismatch_no_drive", dut_low - l0, 0);
    check("mismatch_no_busy", busy_cnt - b0, 0);

    // Aborted write: STOP after 4 data bits
    wq = {8'h96}; write_txn(8'h05); m_write(8'h05);
    w0 = wr_pulses; nacks = 0;
    set_addr(8'h05);
    repeat (4) put_bit(1'b1);
    do_stop();
    check("abort_addr_acks", nacks, 0);
    check("abort_no_pulse", wr_pulses - w0, 0);
    check("abort_busy", busy, 0);
    read_txn(8'h05, 1);
    check("abort_mem_kept", rq[0], 8'h96);
    mptr = 8'h06;

    // Reset while the slave drives a 0 data bit
    wq = {8'h00}; write_txn(8'h20); m_write(8'h20);
    nacks = 0;
    set_addr(8'h20); do_start(); send_cnt(8'hA1);
    check("rstrd_acks", nacks, 0);
    for (int i = 0; i < 4; i++) begin
      get_bit(bt);
      check("rstrd_bit", bt, 0);
    end
    tick(Q);
    check("rstrd_driving", sda, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_sda_release", sda, 1);
    check("rst_busy", busy, 0);
    tick(1); scl = 1'b1; m_oe = 1'b0; tick(2);
    rst = 1'b0; mptr = 8'h00;
    tick(4*Q);
    wq = {8'h5A}; write_txn(8'h07);
    check("post_rst_wr_acks", nacks, 0);
    m_write(8'h07);
    read_txn(8'h07, 1);
    check("post_rst_rd", rq[0], 8'h5A);
    mptr = 8'h08;

`ifdef I2C_SLV_WP_EN
    wq = {8'h77}; write_txn(8'h10); m_write(8'h10);
    wp = 1'b1;
    w0 = wr_pulses; nacks = 0;
    set_addr(8'h10);
    send_byte(8'h3C, nk);
    do_stop();
    check("wp_addr_acks", nacks, 0);
    check("wp_data_nack", nk, 1);
    check("wp_no_pulse", wr_pulses - w0, 0);
    wp = 1'b0;
    read_txn(8'h10, 1);
    check("wp_mem_kept", rq[0], 8'h77);
    mptr = 8'h11;
`endif

    // Randomized traffic in 0x40..0x4F against the model
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
    write_txn(8'h40);
    check("rnd_fill_acks", nacks, 0);
    m_write(8'h40);
    for (int it = 0; it < 20; it++) begin
      a = 8'h40 + 8'($urandom_range(0, 15));
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: begin
          wq.delete();
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
          w0 = wr_pulses;
          write_txn(a);
          check("rnd_wr_acks", nacks, 0);
          check("rnd_wr_pulses", wr_pulses - w0, n);
          m_write(a);
        end
        1: begin
          read_txn(a, n);
          check("rnd_rd_acks", nacks, 0);
          check_reads("rnd_rd", a);
        end
        default: begin
          cur_read(n);
          check("rnd_cur_acks", nacks, 0);
          check_reads("rnd_cur", mptr);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
